// File: rtl/slv_timer.sv
`default_nettype none
// ============================================================================
//  Module   : slv_timer
//  Brief    : Bus-slave 8-bit prescaled down-counter timer with one-shot or
//             periodic reload, sticky timeout flag and level interrupt.
//             Optional PWM output and CMP register enabled by SLV_TIMER_PWM_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module slv_timer #(
  parameter logic [7:0] BASEADDR = 8'hE0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_mst2slv_addr,
  input  logic       s_mst2slv_wr,
  input  logic       s_mst2slv_rd,
  input  logic [7:0] s_mst2slv_data,
  output logic [7:0] s_slv2mst_data,
  output logic       irq
`ifdef SLV_TIMER_PWM_EN
  ,
  output logic       pwm_out
`endif
);

  localparam logic [1:0] C_OFF_TR  = 2'd0;
  localparam logic [1:0] C_OFF_TC  = 2'd1;
  localparam logic [1:0] C_OFF_TS  = 2'd2;
  localparam logic [1:0] C_OFF_CMP = 2'd3;

  logic        w_sel;
  logic        w_wr_tr;
  logic        w_wr_tc;
  logic        w_rd_ts;
  logic        w_tick;
  logic        w_term;
  logic [15:0] w_dmax;

  logic [7:0]  r_cnt;
  logic [7:0]  r_reload;
  logic        r_en;
  logic        r_rep;
  logic        r_ie;
  logic [2:0]  r_ps;
  logic        r_tout;
  logic [15:0] r_pcnt;

  assign w_sel   = (s_mst2slv_addr[7:2] == BASEADDR[7:2]);
  assign w_wr_tr = s_mst2slv_wr & w_sel & (s_mst2slv_addr[1:0] == C_OFF_TR);
  assign w_wr_tc = s_mst2slv_wr & w_sel & (s_mst2slv_addr[1:0] == C_OFF_TC);
  assign w_rd_ts = s_mst2slv_rd & w_sel & (s_mst2slv_addr[1:0] == C_OFF_TS);

  always_comb begin
    w_dmax = 16'd0;
    case (r_ps)
      3'd0:    w_dmax = 16'd0;
      3'd1:    w_dmax = 16'd15;
      3'd2:    w_dmax = 16'd63;
      3'd3:    w_dmax = 16'd255;
      3'd4:    w_dmax = 16'd1023;
      3'd5:    w_dmax = 16'd4095;
      3'd6:    w_dmax = 16'd16383;
      default: w_dmax = 16'd65535;
    endcase
  end

  assign w_tick = r_en & (r_pcnt == w_dmax);
  // A TR write on the same edge discards the tick entirely, including its timeout.
  assign w_term = w_tick & (r_cnt == 8'd0) & ~w_wr_tr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pcnt <= 16'd0;
    end else if (w_wr_tr) begin
      r_pcnt <= 16'd0;
    end else if (w_wr_tc && ((s_mst2slv_data[6:4] != r_ps) || (s_mst2slv_data[0] && !r_en))) begin
      r_pcnt <= 16'd0;
    end else if (!r_en || w_tick) begin
      r_pcnt <= 16'd0;
    end else begin
      r_pcnt <= r_pcnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= 8'd0;
      r_reload <= 8'd0;
    end else if (w_wr_tr) begin
      r_cnt    <= s_mst2slv_data;
      r_reload <= s_mst2slv_data;
    end else if (w_tick) begin
      r_cnt <= (r_cnt == 8'd0) ? r_reload : (r_cnt - 8'd1);
    end
  end

  // A TC write takes precedence over the one-shot auto-disable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_en  <= 1'b0;
      r_rep <= 1'b0;
      r_ie  <= 1'b0;
      r_ps  <= 3'd0;
    end else if (w_wr_tc) begin
      r_en  <= s_mst2slv_data[0];
      r_rep <= s_mst2slv_data[1];
      r_ie  <= s_mst2slv_data[2];
      r_ps  <= s_mst2slv_data[6:4];
    end else if (w_term && !r_rep) begin
      r_en <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tout <= 1'b0;
    end else if (w_term) begin
      r_tout <= 1'b1;
    end else if (w_rd_ts) begin
      r_tout <= 1'b0;
    end
  end

  assign irq = r_tout & r_ie;

`ifdef SLV_TIMER_PWM_EN
  logic       w_wr_cmp;
  logic [7:0] r_cmp;
  logic       r_pwm;

  assign w_wr_cmp = s_mst2slv_wr & w_sel & (s_mst2slv_addr[1:0] == C_OFF_CMP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cmp <= 8'd0;
      r_pwm <= 1'b0;
    end else begin
      if (w_wr_cmp) begin
        r_cmp <= s_mst2slv_data;
      end
      r_pwm <= r_en & (r_cnt < r_cmp);
    end
  end

  assign pwm_out = r_pwm;
`endif

  always_comb begin
    s_slv2mst_data = 8'd0;
    if (s_mst2slv_rd && w_sel) begin
      case (s_mst2slv_addr[1:0])
        C_OFF_TR: s_slv2mst_data = r_cnt;
        C_OFF_TC: s_slv2mst_data = {1'b0, r_ps, 1'b0, r_ie, r_rep, r_en};
        C_OFF_TS: s_slv2mst_data = {r_tout, 6'd0, r_en};
`ifdef SLV_TIMER_PWM_EN
        default:  s_slv2mst_data = r_cmp;
`else
        default:  s_slv2mst_data = 8'd0;
`endif
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_slv_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_slv_timer
//  Brief    : Directed self-checking bench for slv_timer (PWM checks only when
//             SLV_TIMER_PWM_EN is defined).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_slv_timer;

  localparam logic [7:0] C_BASE = 8'hE0;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] addr;
  logic       wr;
  logic       rd;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       irq;
`ifdef SLV_TIMER_PWM_EN
  logic       pwm_out;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  slv_timer #(.BASEADDR(C_BASE)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .s_mst2slv_addr (addr),
    .s_mst2slv_wr   (wr),
    .s_mst2slv_rd   (rd),
    .s_mst2slv_data (wdata),
    .s_slv2mst_data (rdata),
    .irq            (irq)
`ifdef SLV_TIMER_PWM_EN
    ,
    .pwm_out        (pwm_out)
`endif
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Bus tasks start and end on a falling edge; each spans one rising edge.
  task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
    addr  = a;
    wdata = d;
    wr    = 1'b1;
    @(negedge clk);
    wr    = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] d;
    addr = a;
    rd   = 1'b1;
    #1 d = rdata;
    check(tag, d, exp);
    @(negedge clk);
    rd   = 1'b0;
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    check(tag, {7'd0, irq}, {7'd0, exp});
  endtask

`ifdef SLV_TIMER_PWM_EN
  task automatic pwm_count(input string tag, input logic [7:0] exp);
    int c;
    c = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (pwm_out) c++;
    end
    check(tag, 8'(c), exp);
  endtask
`endif

  initial begin
    rst   = 1'b0;
    addr  = 8'h00;
    wr    = 1'b0;
    rd    = 1'b0;
    wdata = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Reset state
    chk_irq("rst_irq", 1'b0);
    check("idle_rd", rdata, 8'h00);
    rd_chk("rst_tr", C_BASE + 8'd0, 8'h00);
    rd_chk("rst_tc", C_BASE + 8'd1, 8'h00);
    rd_chk("rst_ts", C_BASE + 8'd2, 8'h00);
    rd_chk("rst_cmp", C_BASE + 8'd3, 8'h00);

    // One-shot, D = 1: irq rises after the 4th edge following the TC write
    bus_wr(C_BASE + 8'd0, 8'd3);
    bus_wr(C_BASE + 8'd1, 8'h05);
    repeat (3) @(negedge clk);
    chk_irq("os_irq_early", 1'b0);
    @(negedge clk);
    chk_irq("os_irq_rise", 1'b1);
    rd_chk("os_tc", C_BASE + 8'd1, 8'h04);
    rd_chk("os_tr", C_BASE + 8'd0, 8'd3);
    rd_chk("os_ts1", C_BASE + 8'd2, 8'h80);
    rd_chk("os_ts2", C_BASE + 8'd2, 8'h00);
    chk_irq("os_irq_fall", 1'b0);

    // Mid-count reset with TOUT set
    bus_wr(C_BASE + 8'd1, 8'h07);
    repeat (6) @(negedge clk);
    chk_irq("mr_irq_on", 1'b1);
    rst = 1'b0;
    #1 chk_irq("mr_irq_rst", 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rd_chk("mr_tr", C_BASE + 8'd0, 8'h00);
    rd_chk("mr_tc", C_BASE + 8'd1, 8'h00);
    rd_chk("mr_ts", C_BASE + 8'd2, 8'h00);
    rd_chk("mr_cmp", C_BASE + 8'd3, 8'h00);

    // Periodic, D = 16, period 160
    bus_wr(C_BASE + 8'd0, 8'd9);
    bus_wr(C_BASE + 8'd1, 8'h13);
    repeat (20) @(negedge clk);
    rd_chk("per_cnt20", C_BASE + 8'd0, 8'd8);
    repeat (79) @(negedge clk);
    rd_chk("per_cnt100", C_BASE + 8'd0, 8'd3);
    repeat (58) @(negedge clk);
    rd_chk("per_ts_same", C_BASE + 8'd2, 8'h01);
    chk_irq("per_irq_off", 1'b0);
    rd_chk("per_ts_set1", C_BASE + 8'd2, 8'h81);
    repeat (158) @(negedge clk);
    rd_chk("per_ts_pre2", C_BASE + 8'd2, 8'h01);
    rd_chk("per_ts_set2", C_BASE + 8'd2, 8'h81);
    chk_irq("per_irq_off2", 1'b0);

    // TR write landing on a tick edge
    repeat (14) @(negedge clk);
    bus_wr(C_BASE + 8'd0, 8'd5);
    rd_chk("trtick_cnt", C_BASE + 8'd0, 8'd5);
    repeat (15) @(negedge clk);
    rd_chk("trtick_next", C_BASE + 8'd0, 8'd4);

    // Accesses outside the window
    bus_wr(C_BASE + 8'd1, 8'h00);
    bus_wr(C_BASE + 8'd0, 8'h11);
    bus_wr(C_BASE + 8'd4, 8'h55);
    bus_wr(C_BASE + 8'd5, 8'h07);
    rd_chk("oow_tr", C_BASE + 8'd0, 8'h11);
    rd_chk("oow_tc", C_BASE + 8'd1, 8'h00);
    rd_chk("oow_rd", C_BASE + 8'd4, 8'h00);

    // TS is read-only
    bus_wr(C_BASE + 8'd2, 8'hFF);
    rd_chk("ts_ro", C_BASE + 8'd2, 8'h00);

`ifdef SLV_TIMER_PWM_EN
    bus_wr(C_BASE + 8'd0, 8'd7);
    bus_wr(C_BASE + 8'd3, 8'd2);
    rd_chk("cmp_rd", C_BASE + 8'd3, 8'd2);
    bus_wr(C_BASE + 8'd1, 8'h03);
    repeat (8) @(negedge clk);
    pwm_count("pwm_duty", 8'd4);
    bus_wr(C_BASE + 8'd3, 8'd0);
    repeat (2) @(negedge clk);
    pwm_count("pwm_zero", 8'd0);
    bus_wr(C_BASE + 8'd3, 8'hFF);
    repeat (2) @(negedge clk);
    pwm_count("pwm_full", 8'd16);
`else
    bus_wr(C_BASE + 8'd3, 8'h44);
    rd_chk("cmp_absent", C_BASE + 8'd3, 8'h00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/slv_timer.md
# slv_timer

Bus slave timer peripheral that answers the CPU's master data bus (addr/wr/rd/data) and drives the CPU's level-sensitive `irq` input. It provides a prescaled 8-bit down-counter with reload, one-shot or periodic mode, and a sticky timeout flag. It occupies a 4-byte window in the data address space and returns zero on the OR-combined read bus when not addressed.

## Interface
- `BASEADDR`, 8'hE0, base of the 4-byte register window; `BASEADDR[1:0]` must be 0.
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset (0 = reset).
- `s_mst2slv_addr` in 8: bus address.
- `s_mst2slv_wr` in 1: write strobe, one cycle per access.
- `s_mst2slv_rd` in 1: read strobe, one cycle per access.
- `s_mst2slv_data` in 8: write data.
- `s_slv2mst_data` out 8: read data; 8'd0 unless a read hits the window.
- `irq` out 1: active-high level interrupt request.
- `pwm_out` out 1: PWM output; present only with `SLV_TIMER_PWM_EN`.

## Operation
- Select: `sel = (addr[7:2] == BASEADDR[7:2])`. Writes and reads take effect only when `sel` is true.
- Register map, by offset:
  - +0 TR, W: reload value. A write loads both `reload` and `cnt` and clears the prescaler. R: current `cnt`.
  - +1 TC, R/W: [0] EN, [1] REP (1 = periodic), [2] IE, [6:4] PS, [7] reads 0.
  - +2 TS, R: [7] TOUT, [0] EN, others 0. Reading TS clears TOUT. Writes are ignored.
  - +3 CMP, R/W with `SLV_TIMER_PWM_EN`; otherwise reads 0 and writes are ignored.
- Prescaler:
  - 16-bit `pcnt`; divisor D = 1, 16, 64, 256, 1024, 4096, 16384, 65536 for PS = 0..7.
  - While EN = 1: `tick` = (`pcnt == D-1`). On tick `pcnt` goes to 0, otherwise it increments.
  - While EN = 0: `pcnt` is held at 0.
  - A TC write that changes PS, or sets EN from 0 to 1, clears `pcnt`.
- Counter behaviour on `tick`:
  - If `cnt == 0`: set TOUT, then `cnt <= reload`. If REP = 0, also clear EN (one-shot).
  - Otherwise `cnt <= cnt - 1`.
  - Arithmetic is 8-bit unsigned; no wrap below 0, because 0 always reloads.
- `irq = TOUT & IE`, combinational from registers. Setting IE while TOUT = 1 asserts `irq` immediately.
- Simultaneous events:
  - TOUT set and TS read in the same cycle: set wins, TOUT stays 1 and the read returns the pre-edge value.
  - TR write on a tick cycle: the write wins, the tick is discarded, and TOUT is unaffected.
  - A TC write clearing EN on the terminal tick: TOUT is still set, and EN = 0.
- Reset values:
  - `cnt`, `reload`, TC, TOUT, `pcnt`, CMP all 0.
  - `irq` = 0, `s_slv2mst_data` = 0, `pwm_out` = 0.
  - Asserting reset mid-count aborts immediately with no pending flag.

## Timing
- Write: data is captured on the rising edge where `wr & sel`. The new value is visible on the next cycle.
- Read: combinational. `s_slv2mst_data` is valid in the same cycle as `rd & sel`. The TS clear-on-read takes effect at that cycle's edge.
- Period (REP = 1) is (TR + 1) × D cycles.
- With D = 1, if EN is written at edge k and TR = N is already loaded, TOUT rises after edge k+N+1.
- `irq` follows TOUT with zero added latency. It drops after the edge of the clearing TS read.
- `pwm_out` is registered: `pwm_out <= EN & (cnt < CMP)`, giving one cycle of latency from `cnt`/CMP.

## Configuration
- `SLV_TIMER_PWM_EN` defined:
  - CMP register at +3 and the `pwm_out` port exist.
  - Duty in periodic mode is CMP/(TR+1). CMP = 0 gives constant 0; CMP > TR gives constant 1 while EN = 1.
- Not defined:
  - No `pwm_out` port and no CMP register.
  - Offset +3 reads 8'd0 and writes are ignored.

## Test plan
- Reset: drive `rst` = 0 mid-count with TOUT = 1. Required: `irq` = 0 and all registers read 0 after `rst` = 1.
- One-shot, D = 1:
  - Stimulus: TR ← 3, TC ← 8'h05 (EN, IE).
  - Required: `irq` rises 4 cycles after the TC write edge; TC reads 8'h04; TS reads 8'h80, then 8'h00 on the next read; `irq` falls.
- Periodic, D = 16:
  - Stimulus: TR ← 9, TC ← 8'h13.
  - Required: TOUT sets every 160 cycles; TR read shows a descending `cnt`; `irq` stays 0 because IE = 0.
- Boundary:
  - TS read on the same cycle TOUT sets: required read 0, flag remains 1.
  - TR write on a tick cycle: required `cnt` = new value.
  - Access at BASEADDR+4: required no effect and read data 0.
- PWM, with the macro:
  - Stimulus: TR ← 7, CMP ← 2, TC ← 8'h03.
  - Required: `pwm_out` is high for 2 of every 8 cycles.
  - CMP ← 0 gives constant low; CMP ← 8'hFF gives constant high.
- Without the macro: a write to +3 is ignored and reads return 8'd0.
